// File: rtl/out_port_uart_tx_pkg.sv
// ============================================================================
// Module   : out_port_uart_tx_pkg
// Brief    : Shared FSM state encoding and default sizing for the OUT-port
//            UART transmitter (parity state used only with UART_TX_PARITY_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package out_port_uart_tx_pkg;

    // Transmit FSM states; PARITY is only reachable when parity is built in
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 16;
    localparam int DEFAULT_FIFO_DEPTH   = 4;

endpackage

`default_nettype wire

// File: rtl/out_port_uart_tx_fifo.sv
// ============================================================================
// Module   : sync_fifo_8b
// Brief    : 8-bit synchronous FIFO with push/pop/full/empty/count. A push
//            while full is accepted only when a pop happens in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_8b
    import out_port_uart_tx_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          CK,
    input  logic          RST,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n)
    always_ff @(posedge CK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; when full, push and pop share a slot but the head is read before the write lands
    always_ff @(posedge CK) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

`default_nettype wire

// File: rtl/out_port_uart_tx.sv
// ============================================================================
// Module   : out_port_uart_tx
// Brief    : Buffers bytes written by the CPU OUT instruction and sends them
//            as async serial (8N1) on TXD. Define UART_TX_PARITY_EN to insert
//            an even-parity bit between the data bits and the stop bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module out_port_uart_tx
    import out_port_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
    input  logic       CK,
    input  logic       RST,
    input  logic       WR,
    input  logic [7:0] DIN,
    output logic       TXD,
    output logic       BUSY,
    output logic       FULL,
    output logic       OVF
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_t     state;
    tx_state_t     state_next;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          txd_next;
    logic          pop;
    logic          bit_done;
    logic [7:0]    fifo_dout;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
`ifdef UART_TX_PARITY_EN
    logic          parity_bit;
`endif

    sync_fifo_8b #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CK    (CK),
        .RST   (RST),
        .push  (WR),
        .pop   (pop),
        .din   (DIN),
        .dout  (fifo_dout),
        .full  (FULL),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bit_done = (baud_cnt == BW'(CLKS_PER_BIT - 1));
    assign BUSY     = (fifo_count != '0) || (state != ST_IDLE);

    // State register
    always_ff @(posedge CK) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state, FIFO pop request and line level for the current state
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        txd_next   = 1'b1;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                txd_next = 1'b0;
                if (bit_done) state_next = ST_DATA;
            end
            ST_DATA: begin
                txd_next = shift_reg[0];
                if (bit_done && (bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    state_next = ST_PARITY;
`else
                    state_next = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                txd_next = parity_bit;
                if (bit_done) state_next = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (bit_done) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: baud timing, bit index, shifter, registered line output and overflow flag
    always_ff @(posedge CK) begin
        if (RST) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            TXD       <= 1'b1;
            OVF       <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            TXD <= txd_next;

            if ((state != state_next) || bit_done || (state == ST_IDLE))
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 1'b1;

            if (state == ST_DATA) begin
                if (bit_done) bit_idx <= bit_idx + 1'b1;
            end else begin
                bit_idx <= '0;
            end

            if (pop)
                shift_reg <= fifo_dout;
            else if ((state == ST_DATA) && bit_done)
                shift_reg <= {1'b0, shift_reg[7:1]};

`ifdef UART_TX_PARITY_EN
            if (pop) parity_bit <= ^fifo_dout;
`endif

            if (WR && FULL && !pop) OVF <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_out_port_uart_tx.sv
// ============================================================================
// Module   : tb_out_port_uart_tx
// Brief    : Directed self-checking bench for out_port_uart_tx
//            (CLKS_PER_BIT=4, FIFO_DEPTH=4; honours UART_TX_PARITY_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_out_port_uart_tx;

    localparam int CPB = 4;
    localparam int FD  = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int P = FRAME_BITS * CPB + 1;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        int         t;
    } frame_t;

    logic       CK = 1'b0;
    logic       RST;
    logic       WR;
    logic [7:0] DIN;
    logic       TXD;
    logic       BUSY;
    logic       FULL;
    logic       OVF;

    int     tests = 0;
    int     fails = 0;
    int     cyc   = 0;
    frame_t rxq[$];
    frame_t mon_f;
    logic   mon_busy = 1'b0;
    int     mon_cnt  = 0;

    out_port_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (FD)
    ) dut (
        .CK   (CK),
        .RST  (RST),
        .WR   (WR),
        .DIN  (DIN),
        .TXD  (TXD),
        .BUSY (BUSY),
        .FULL (FULL),
        .OVF  (OVF)
    );

    always #5 CK = ~CK;

    // Line decoder: finds each start bit and samples every bit mid-period
    always @(negedge CK) begin
        if (RST === 1'b1) begin
            mon_busy = 1'b0;
        end else if (!mon_busy) begin
            if (TXD === 1'b0) begin
                mon_busy = 1'b1;
                mon_cnt  = 0;
                mon_f.t  = cyc;
                mon_f.par = 1'b0;
            end
        end else begin
            mon_cnt++;
            if ((mon_cnt % CPB) == CPB / 2) begin
                if ((mon_cnt / CPB) >= 1 && (mon_cnt / CPB) <= 8)
                    mon_f.data[(mon_cnt / CPB) - 1] = TXD;
                else if ((mon_cnt / CPB) == 9 && FRAME_BITS == 11)
                    mon_f.par = TXD;
                if ((mon_cnt / CPB) == FRAME_BITS - 1) begin
                    mon_f.stop = TXD;
                    rxq.push_back(mon_f);
                    mon_busy = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge CK);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        repeat (2) step();
        RST = 1'b0;
        rxq.delete();
    endtask

    task automatic wait_frames(input int n);
        int k = 0;
        while (rxq.size() < n && k < 3000) begin
            step();
            k++;
        end
        check("rx_frame_count", rxq.size(), n);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (BUSY !== 1'b0 && k < 3000) begin
            step();
            k++;
        end
        check("idle_timeout", BUSY, 1'b0);
        repeat (3) step();
    endtask

    function automatic logic exp_line(input int i, input logic [7:0] b);
        int slot = i / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot - 1];
        if (slot == 9 && FRAME_BITS == 11) return ^b;
        return 1'b1;
    endfunction

    initial begin
        logic [7:0] byte_a5;
        int lows;

        RST = 1'b1;
        WR  = 1'b0;
        DIN = 8'h00;

        // 1: reset with a write attempted while reset is held
        WR  = 1'b1;
        DIN = 8'h55;
        repeat (2) step();
        WR  = 1'b0;
        RST = 1'b0;
        check("rst_txd",  TXD,  1'b1);
        check("rst_busy", BUSY, 1'b0);
        check("rst_full", FULL, 1'b0);
        check("rst_ovf",  OVF,  1'b0);
        repeat (5) step();
        check("rst_wr_ignored", BUSY, 1'b0);
        rxq.delete();

        // 2: single byte 0xA5, exact line waveform and BUSY release
        byte_a5 = 8'hA5;
        WR  = 1'b1;
        DIN = byte_a5;
        step();
        WR  = 1'b0;
        check("single_busy", BUSY, 1'b1);
        step();
        check("single_txd_pre", TXD, 1'b1);
        for (int i = 0; i < FRAME_BITS * CPB; i++) begin
            step();
            check($sformatf("single_txd[%0d]", i), TXD, exp_line(i, byte_a5));
            if (i == FRAME_BITS * CPB - 2) check("single_busy_last", BUSY, 1'b1);
            if (i == FRAME_BITS * CPB - 1) check("single_busy_drop", BUSY, 1'b0);
        end
        wait_idle();

        // 3: burst of six writes, sixth dropped as overflow
        rxq.delete();
        for (int i = 0; i < 6; i++) begin
            WR  = 1'b1;
            DIN = 8'(i + 1);
            step();
            if (i == 4) begin
                check("burst_full", FULL, 1'b1);
                check("burst_ovf_before", OVF, 1'b0);
            end
            if (i == 5) check("burst_ovf", OVF, 1'b1);
        end
        WR = 1'b0;
        wait_frames(5);
        for (int i = 0; i < 5 && i < rxq.size(); i++) begin
            check($sformatf("burst_data[%0d]", i), rxq[i].data, 8'(i + 1));
            check($sformatf("burst_stop[%0d]", i), rxq[i].stop, 1'b1);
            if (i > 0) check($sformatf("burst_period[%0d]", i), rxq[i].t - rxq[i-1].t, P);
        end
        repeat (2 * P) step();
        check("burst_no_extra", rxq.size(), 5);
        check("burst_busy_end", BUSY, 1'b0);
        check("burst_ovf_sticky", OVF, 1'b1);

        // 4: FIFO full, write lands on the pop cycle and is accepted
        do_reset();
        for (int i = 0; i < 5; i++) begin
            WR  = 1'b1;
            DIN = 8'(8'h11 + i);
            step();
        end
        WR = 1'b0;
        check("fullpop_full", FULL, 1'b1);
        repeat (P - 4) step();
        WR  = 1'b1;
        DIN = 8'h16;
        step();
        WR  = 1'b0;
        check("fullpop_ovf", OVF, 1'b0);
        check("fullpop_full_after", FULL, 1'b1);
        wait_frames(6);
        for (int i = 0; i < 6 && i < rxq.size(); i++)
            check($sformatf("fullpop_data[%0d]", i), rxq[i].data, 8'(8'h11 + i));
        wait_idle();
        check("fullpop_ovf_end", OVF, 1'b0);

        // 5: reset during data bit 3 of 0xFF with another byte queued
        rxq.delete();
        WR  = 1'b1;
        DIN = 8'hFF;
        step();
        DIN = 8'h00;
        step();
        WR  = 1'b0;
        repeat (17) step();
        check("midrst_busy_before", BUSY, 1'b1);
        RST = 1'b1;
        step();
        check("midrst_txd",  TXD,  1'b1);
        check("midrst_busy", BUSY, 1'b0);
        check("midrst_full", FULL, 1'b0);
        check("midrst_ovf",  OVF,  1'b0);
        RST = 1'b0;
        rxq.delete();
        lows = 0;
        for (int i = 0; i < 3 * P; i++) begin
            step();
            if (TXD !== 1'b1) lows++;
        end
        check("midrst_line_quiet", lows, 0);
        check("midrst_no_frame", rxq.size(), 0);

`ifdef UART_TX_PARITY_EN
        // 6: parity bit values and frame length
        rxq.delete();
        WR  = 1'b1;
        DIN = 8'hA5;
        step();
        DIN = 8'h07;
        step();
        WR  = 1'b0;
        wait_frames(2);
        if (rxq.size() >= 2) begin
            check("par_a5", rxq[0].par, 1'b0);
            check("par_07_data", rxq[1].data, 8'h07);
            check("par_07", rxq[1].par, 1'b1);
            check("par_period", rxq[1].t - rxq[0].t, 45);
        end
        wait_idle();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
